// File: rtl/sum_acc_pkg.sv
// sum_acc_pkg: shared FSM state type and signed saturation limits for the frame accumulator
package sum_acc_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    function automatic longint sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

endpackage

// File: rtl/sat_adder.sv
// sat_adder: combinational signed ACC_W + DATA_W add, clamped to the ACC_W signed range
module sat_adder
    import sum_acc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic [ACC_W-1:0]  a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    localparam logic [ACC_W-1:0] MAX = ACC_W'(sat_max(ACC_W));
    localparam logic [ACC_W-1:0] MIN = ~MAX;

    logic [ACC_W:0] full;

    assign full = {a[ACC_W-1], a} + {{(ACC_W + 1 - DATA_W){b[DATA_W-1]}}, b};
    // one guard bit is enough: DATA_W < ACC_W keeps the true sum inside ACC_W+1 bits
    assign ovf  = full[ACC_W] ^ full[ACC_W-1];
    assign sum  = ovf ? (full[ACC_W] ? MIN : MAX) : full[ACC_W-1:0];

endmodule

// File: rtl/sum_frame_accumulator.sv
// sum_frame_accumulator: saturating frame accumulator with valid/ready result
// SUM_ACC_AVG_EN: when defined, out_data is the frame mean (sum >>> log2(FRAME_LEN))
module sum_frame_accumulator
    import sum_acc_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 16,
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_ovf,
    output logic              busy
);

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, sum;
    logic [CNT_W-1:0]        cnt_q;
    logic                    add_ovf, xfer, last;

    sat_adder #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_add (
        .a   (acc_q),
        .b   (in_data),
        .sum (sum),
        .ovf (add_ovf)
    );

`ifdef SUM_ACC_AVG_EN
    logic signed [ACC_W-1:0] result;
    assign result = sum >>> $clog2(FRAME_LEN);
`else
    logic [ACC_W-1:0] result;
    assign result = sum;
`endif

    assign in_ready  = state_q == ACCUM;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign xfer      = in_valid & in_ready;
    assign last      = cnt_q == CNT_W'(FRAME_LEN - 1);

    always_comb begin
        state_d = state_q;
        state_d = (state_q == IDLE)  ? (start ? ACCUM : IDLE) :
                  (state_q == ACCUM) ? ((xfer && last) ? DONE : ACCUM) :
                                       (out_ready ? IDLE : DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            out_data <= '0;
            out_ovf  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                acc_q   <= '0;
                cnt_q   <= '0;
                out_ovf <= 1'b0;
            end
            // result is captured on the last transfer so out_data holds through DONE and IDLE
            if (xfer) begin
                acc_q   <= sum;
                cnt_q   <= cnt_q + CNT_W'(1);
                out_ovf <= out_ovf | add_ovf;
                if (last) out_data <= result;
            end
        end
    end

endmodule

// File: tb/tb_sum_frame_accumulator.sv
// tb_sum_frame_accumulator: directed frames on a 16-bit and a 9-bit accumulator sharing one stimulus
module tb_sum_frame_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b0;

    logic        in_ready, out_valid, out_ovf, busy;
    logic [15:0] out_data;
    logic        in_ready9, out_valid9, out_ovf9, busy9;
    logic [8:0]  out_data9;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sum_frame_accumulator #(.DATA_W(8), .ACC_W(16), .FRAME_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ovf(out_ovf), .busy(busy)
    );

    sum_frame_accumulator #(.DATA_W(8), .ACC_W(9), .FRAME_LEN(4)) dut9 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready9),
        .in_data(in_data), .out_valid(out_valid9), .out_ready(out_ready), .out_data(out_data9),
        .out_ovf(out_ovf9), .busy(busy9)
    );

    typedef struct {
        logic [3:0][7:0] d;
        int              gap;
        int              hold;
        bit              start_rel;
        int              sum16;
        bit              ovf16;
        int              sum9;
        bit              ovf9;
    } vec_t;

    vec_t vecs [7];

    function automatic int expect_out(input int s);
`ifdef SUM_ACC_AVG_EN
        return s >>> 2;
`else
        return s;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_result(input string tag, input vec_t v);
        chk({tag, "_data16"}, int'($signed(out_data)), expect_out(v.sum16));
        chk({tag, "_ovf16"}, int'(out_ovf), int'(v.ovf16));
        chk({tag, "_data9"}, int'($signed(out_data9)), expect_out(v.sum9));
        chk({tag, "_ovf9"}, int'(out_ovf9), int'(v.ovf9));
    endtask

    task automatic run_frame(input vec_t v);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("in_ready_accum", int'(in_ready & in_ready9), 1);
        chk("busy_accum", int'(busy & busy9), 1);
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < v.gap; g++) begin
                in_valid = 1'b0;
                in_data  = 8'hAA;
                start    = 1'b1;
                @(negedge clk);
                start = 1'b0;
                chk("in_ready_gap", int'(in_ready & in_ready9), 1);
                chk("out_valid_gap", int'(out_valid | out_valid9), 0);
            end
            in_valid = 1'b1;
            in_data  = v.d[i];
            @(negedge clk);
            chk("out_valid_latency", int'(out_valid), int'(i == 3));
            chk("out_valid9_latency", int'(out_valid9), int'(i == 3));
        end
        in_valid = 1'b0;
        chk("in_ready_done", int'(in_ready | in_ready9), 0);
        chk_result("done", v);
        for (int h = 0; h < v.hold; h++) begin
            start = (h == 1);
            @(negedge clk);
            start = 1'b0;
            chk("out_valid_hold", int'(out_valid & out_valid9), 1);
            chk_result("hold", v);
        end
        start     = v.start_rel;
        out_ready = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b0;
        chk("out_valid_drop", int'(out_valid | out_valid9), 0);
        chk("busy_idle", int'(busy | busy9), 0);
        chk("in_ready_idle", int'(in_ready | in_ready9), 0);
        @(negedge clk);
        chk("still_idle", int'(busy | busy9), 0);
        chk_result("idle_keep", v);
    endtask

    initial begin
        vecs[0] = '{32'h55555555, 0, 5, 1'b1,  340, 1'b0,  255, 1'b1};
        vecs[1] = '{32'h80808080, 2, 0, 1'b0, -512, 1'b0, -256, 1'b1};
        vecs[2] = '{32'h017F8040, 0, 0, 1'b0,   64, 1'b0,   64, 1'b0};
        vecs[3] = '{32'hFEFE00FF, 1, 2, 1'b1,   -5, 1'b0,   -5, 1'b0};
        vecs[4] = '{32'h7F7F7F7F, 0, 0, 1'b0,  508, 1'b0,  255, 1'b1};
        vecs[5] = '{32'h01010101, 0, 0, 1'b0,    4, 1'b0,    4, 1'b0};
        vecs[6] = '{32'h807F7F7F, 0, 1, 1'b0,  253, 1'b0,  127, 1'b1};

        #12;
        chk("rst_in_ready", int'(in_ready | in_ready9), 0);
        chk("rst_out_valid", int'(out_valid | out_valid9), 0);
        chk("rst_out_data", int'(out_data) + int'(out_data9), 0);
        chk("rst_out_ovf", int'(out_ovf | out_ovf9), 0);
        chk("rst_busy", int'(busy | busy9), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 7; k++) run_frame(vecs[k]);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h10;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midrst_in_ready", int'(in_ready | in_ready9), 0);
        chk("midrst_busy", int'(busy | busy9), 0);
        chk("midrst_out_valid", int'(out_valid | out_valid9), 0);
        chk("midrst_out_data", int'(out_data) + int'(out_data9), 0);
        chk("midrst_out_ovf", int'(out_ovf | out_ovf9), 0);
        @(negedge clk);
        chk("midrst_no_valid", int'(out_valid | out_valid9), 0);
        rst_n = 1'b1;
        run_frame(vecs[5]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
